// File: rtl/adc_ob_reader_pkg.sv
// ============================================================================
// adc_ob_reader_pkg : shared types and helpers for the serial ADC reader
// Rev 1.0
// ============================================================================
`default_nettype none

package adc_ob_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Counter width able to hold the value n itself (not just n-1).
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_ob_reader_peak.sv
// ============================================================================
// adc_ob_reader_peak : clearable peak hold of one's-complement sample magnitude
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_ob_reader_peak
  import adc_ob_reader_pkg::*;
#(
  parameter int WS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          v,
  input  logic [WS-1:0] i,
  output logic [WS-1:0] pk
);

  // ~i for negatives keeps the MSB clear, so the most negative code cannot overflow.
  logic [WS-1:0] w_mag;
  assign w_mag = i[WS-1] ? ~i : i;

  always_ff @(posedge clk) begin
    if (rst) begin
      pk <= '0;
    end else if (v) begin
      pk <= (clr || (w_mag > pk)) ? w_mag : pk;
    end else if (clr) begin
      pk <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_ob_reader.sv
// ============================================================================
// adc_ob_reader : SPI-style offset-binary ADC reader with signed output and peak hold
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_ob_reader
  import adc_ob_reader_pkg::*;
#(
  parameter int WS  = 16,
  parameter int DIV = 4,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          adc_sdo,
  output logic          adc_sclk,
  output logic          adc_cs_n,
  output logic [WS-1:0] o,
  output logic          o_valid,
  output logic          busy,
  input  logic          pk_clr,
  output logic [WS-1:0] pk
);

  localparam int DW = cnt_width(DIV);
  localparam int BW = cnt_width(WS);
  localparam int GW = cnt_width(GAP);

  localparam logic [DW-1:0] C_DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] C_BIT_LAST = BW'(WS);
  localparam logic [GW-1:0] C_GAP_LAST = GW'(GAP - 1);

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit;
  logic [GW-1:0] r_gap;
  logic [WS-1:0] r_sh;

  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      o        <= '0;
      o_valid  <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_gap    <= '0;
      r_sh     <= '0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state  <= ST_SHIFT;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
          end
        end
        ST_SHIFT: begin
          // Each sclk phase lasts DIV cycles; data is captured as sclk rises.
          if (r_div == C_DIV_LAST) begin
            r_div <= '0;
            if (!adc_sclk) begin
              adc_sclk <= 1'b1;
              r_sh     <= {r_sh[WS-2:0], adc_sdo};
              r_bit    <= r_bit + BW'(1);
            end else begin
              adc_sclk <= 1'b0;
              if (r_bit == C_BIT_LAST) begin
                r_state  <= ST_DONE;
                adc_cs_n <= 1'b1;
              end
            end
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        ST_DONE: begin
          // Offset binary to two's complement is an MSB flip.
          o       <= {~r_sh[WS-1], r_sh[WS-2:0]};
          o_valid <= 1'b1;
          r_gap   <= '0;
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (r_gap == C_GAP_LAST) begin
            if (en) begin
              r_state  <= ST_SHIFT;
              adc_cs_n <= 1'b0;
              adc_sclk <= 1'b0;
              r_div    <= '0;
              r_bit    <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  adc_ob_reader_peak #(
    .WS (WS)
  ) u_peak (
    .clk (clk),
    .rst (rst),
    .clr (pk_clr),
    .v   (o_valid),
    .i   (o),
    .pk  (pk)
  );

endmodule

`default_nettype wire

// File: tb/tb_adc_ob_reader.sv
// ============================================================================
// tb_adc_ob_reader : bench for adc_ob_reader with ADC pin model and scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adc_ob_reader;

  localparam int WS  = 16;
  localparam int DIV = 2;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          adc_sdo = 1'b0;
  logic          adc_sclk;
  logic          adc_cs_n;
  logic [WS-1:0] o;
  logic          o_valid;
  logic          busy;
  logic          pk_clr = 1'b0;
  logic [WS-1:0] pk;

  adc_ob_reader #(
    .WS  (WS),
    .DIV (DIV),
    .GAP (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .adc_sdo  (adc_sdo),
    .adc_sclk (adc_sclk),
    .adc_cs_n (adc_cs_n),
    .o        (o),
    .o_valid  (o_valid),
    .busy     (busy),
    .pk_clr   (pk_clr),
    .pk       (pk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- ADC pin model ----------------
  logic [WS-1:0] adc_q[$];
  logic [WS-1:0] cur_word = '0;
  int            bit_idx = 0;

  always @(negedge adc_cs_n) begin
    cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : WS'($urandom);
    bit_idx  = WS - 1;
    adc_sdo  = cur_word[bit_idx];
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0 && bit_idx > 0) begin
      bit_idx = bit_idx - 1;
      adc_sdo = cur_word[bit_idx];
    end
  end

  // ---------------- reference model ----------------
  logic [WS-1:0] exp_q[$];
  int  o_model = 0;
  int  pk_m = 0;
  bit  mon_on = 0;
  int  cyc = 0;
  int  sclk_rises = 0, last_rises = 0;
  int  cs_falls[$];
  int  hi_run = 0, hi_run_last = 0;
  logic prev_cs = 1'b1;

  always @(posedge adc_sclk) sclk_rises++;
  always @(negedge adc_cs_n) sclk_rises = 0;

  // A completed word is owed to the output unless reset cut the frame short.
  always @(posedge adc_cs_n) begin
    if (rst !== 1'b1) begin
      if (mon_on) chk("sclk rises per frame", sclk_rises, WS);
      last_rises = sclk_rises;
      exp_q.push_back(cur_word);
    end
  end

  always @(posedge clk) begin
    int mag;
    cyc++;
    if (rst) begin
      pk_m    = 0;
      o_model = 0;
      exp_q.delete();
    end else if (o_valid) begin
      mag  = (o_model < 0) ? (-o_model - 1) : o_model;
      pk_m = (pk_clr || mag > pk_m) ? mag : pk_m;
    end else if (pk_clr) begin
      pk_m = 0;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("pk track", pk, pk_m);
      if (o_valid) begin
        if (exp_q.size() == 0) chk("spurious o_valid", 1, 0);
        else o_model = int'(exp_q.pop_front()) - 32768;
      end
      chk("o track", 32'($signed(o)), 32'(o_model));
      if (prev_cs === 1'b1 && adc_cs_n === 1'b0) cs_falls.push_back(cyc);
      if (adc_cs_n && busy) hi_run++;
      else if (!adc_cs_n) begin
        if (hi_run > 0) hi_run_last = hi_run;
        hi_run = 0;
      end else hi_run = 0;
    end
    prev_cs = adc_cs_n;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (o_valid !== 1'b1 && n < 400) begin tick(); n++; end
    if (o_valid !== 1'b1) chk({nm, " valid timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin tick(); n++; end
    if (busy !== 1'b0) chk({nm, " idle timeout"}, 1, 0);
  endtask

  task automatic pulse_clr();
    pk_clr = 1'b1; tick(); pk_clr = 1'b0;
  endtask

  typedef struct {
    logic [WS-1:0] word;
    logic [WS-1:0] exp_o;
    logic [WS-1:0] exp_pk;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{16'h8000, 16'h0000, 16'h0000};
    vecs[1] = '{16'hFFFF, 16'h7FFF, 16'h7FFF};
    vecs[2] = '{16'h0000, 16'h8000, 16'h7FFF};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 16'h0000};
    vecs[4] = '{16'h8001, 16'h0001, 16'h0001};
    vecs[5] = '{16'h7000, 16'hF000, 16'h0FFF};
    vecs[6] = '{16'h9000, 16'h1000, 16'h1000};
    vecs[7] = '{16'h0001, 16'h8001, 16'h7FFE};

    // Reset state
    repeat (3) tick();
    chk("reset cs_n", adc_cs_n, 1);
    chk("reset sclk", adc_sclk, 0);
    chk("reset o", o, 0);
    chk("reset o_valid", o_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset pk", pk, 0);
    rst = 1'b0;
    mon_on = 1;
    tick();

    // Latency: 0x8000 -> 0, strobe on the 66th cycle counted from cs_n low
    adc_q.push_back(16'h8000);
    en = 1'b1; tick(); en = 1'b0;
    chk("cs_n low after start", adc_cs_n, 0);
    n = 1;
    while (o_valid !== 1'b1 && n < 200) begin tick(); n++; end
    chk("latency cycles", n, 66);
    chk("latency o", o, 16'h0000);
    tick();
    chk("latency o_valid one cycle", o_valid, 0);
    chk("latency pk", pk, 16'h0000);
    wait_idle("latency");

    // Table of single frames
    for (int k = 0; k < 8; k++) begin
      pulse_clr();
      adc_q.push_back(vecs[k].word);
      en = 1'b1; tick(); en = 1'b0;
      wait_valid("table");
      chk($sformatf("table o[%0d]", k), o, vecs[k].exp_o);
      tick();
      chk($sformatf("table pk[%0d]", k), pk, vecs[k].exp_pk);
      wait_idle("table");
    end

    // Back-to-back frames: period and cs_n high time
    pulse_clr();
    cs_falls.delete();
    hi_run_last = 0;
    adc_q.push_back(16'hFFFF);
    adc_q.push_back(16'h0000);
    en = 1'b1;
    wait_valid("b2b first");
    chk("b2b o first", o, 16'h7FFF);
    tick();
    wait_valid("b2b second");
    chk("b2b o second", o, 16'h8000);
    en = 1'b0;
    tick();
    chk("b2b pk", pk, 16'h7FFF);
    if (cs_falls.size() >= 2) chk("b2b frame period", cs_falls[1] - cs_falls[0], 67);
    else chk("b2b frame count", cs_falls.size(), 2);
    chk("b2b cs_n high cycles", hi_run_last, 3);
    wait_idle("b2b");

    // Single-cycle en: exactly one frame
    cs_falls.delete();
    adc_q.push_back(16'h0000);
    en = 1'b1; tick(); en = 1'b0;
    wait_valid("pulse");
    wait_idle("pulse");
    repeat (5) tick();
    chk("pulse frames", cs_falls.size(), 1);
    chk("pulse sclk rises", last_rises, 16);
    chk("pulse busy", busy, 0);

    // Reset mid-frame at bit 7; pk is nonzero going in
    adc_q.push_back(16'h1234);
    en = 1'b1; tick(); en = 1'b0;
    n = 0;
    while (sclk_rises < 7 && n < 200) begin tick(); n++; end
    chk("rst reached bit 7", sclk_rises, 7);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst cs_n", adc_cs_n, 1);
    chk("rst sclk", adc_sclk, 0);
    chk("rst o", o, 0);
    chk("rst pk", pk, 0);
    chk("rst busy", busy, 0);
    n = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (o_valid === 1'b1) n++;
    end
    chk("rst no o_valid", n, 0);

    // Peak hold with coincident clear
    pulse_clr();
    adc_q.push_back(16'h9000);
    adc_q.push_back(16'h7000);
    adc_q.push_back(16'h8100);
    en = 1'b1;
    wait_valid("pk 9000");
    tick();
    wait_valid("pk 7000");
    tick();
    chk("pk after 9000,7000", pk, 16'h1000);
    n = 0;
    while (adc_cs_n !== 1'b0 && n < 20) begin tick(); n++; end
    en = 1'b0;
    wait_valid("pk 8100");
    pk_clr = 1'b1; tick(); pk_clr = 1'b0;
    chk("pk clr with valid", pk, 16'h0100);
    wait_idle("pk");
    pulse_clr();
    chk("pk clr alone", pk, 16'h0000);

    // en dropped mid-SHIFT
    cs_falls.delete();
    en = 1'b1;
    repeat (20) tick();
    en = 1'b0;
    wait_valid("drop");
    n = 0;
    while (busy !== 1'b0 && n < 20) begin tick(); n++; end
    chk("drop cycles to idle", n, 2);
    repeat (10) tick();
    chk("drop frames", cs_falls.size(), 1);
    chk("drop busy", busy, 0);

    // Randomized en / pk_clr against the scoreboard
    for (int c = 0; c < 1500; c++) begin
      en     = ($urandom_range(0, 3) != 0);
      pk_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    en = 1'b0;
    pk_clr = 1'b0;
    wait_idle("random");
    repeat (5) tick();
    chk("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
